// File: rtl/key_onehot_scan_if.sv
// Key scanner bus: raw key inputs in, accepted one-hot key out.
//
// Signals:
//   iKEY     10  raw asynchronous keys, bit k = digit k, 1 = pressed
//   oONEHOT  10  last accepted key, one-hot (all zeros = none since reset)
//   oVALID    1  one-cycle strobe when a new key is accepted
//   oMULTI    1  high while a rejected multi-key press is held
//
// Modports:
//   master  the keypad / encoder side: drives iKEY, observes the results
//   slave   the scanner itself: samples iKEY, drives the results
interface key_onehot_scan_if;
  logic [9:0] iKEY;
  logic [9:0] oONEHOT;
  logic       oVALID;
  logic       oMULTI;

  modport master (
    output iKEY,
    input  oONEHOT,
    input  oVALID,
    input  oMULTI
  );

  modport slave (
    input  iKEY,
    output oONEHOT,
    output oVALID,
    output oMULTI
  );
endinterface

// File: rtl/key_onehot_scan.sv
// key_onehot_scan: front end for the 10-input one-hot encoder.
//
// Synchronises ten raw key inputs, debounces them as a group and accepts
// exactly one key press at a time. An accepted key is held on oONEHOT and
// announced with a one-cycle oVALID; multi-key presses raise oMULTI instead
// and never reach oONEHOT.
//
// Ports:
//   iCLK   system clock, all logic on the rising edge
//   iRSTn  synchronous active-low reset
//   bus    key_onehot_scan_if.slave (iKEY in; oONEHOT, oVALID, oMULTI out)
//
// Parameters:
//   DEBOUNCE_CYCLES  unchanged cycles needed to call the keys stable (2 .. 2**CNT_W-1)
//   CNT_W            width of the debounce counter
module key_onehot_scan #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic              iCLK,
  input logic              iRSTn,
  key_onehot_scan_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LOCK = 2'd2
  } state_t;

  logic [9:0]       sync1_q;
  logic [9:0]       sync2_q;
  logic [9:0]       prev_q;
  logic [9:0]       stable_q;
  logic [9:0]       stableNext;
  logic [2:0]       fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             armed_q;
  logic             armed_d;
  logic             keySingle;
  logic             keyMulti;

  state_t           state_q;
  state_t           state_d;
  logic [9:0]       onehot_q;
  logic [9:0]       onehot_d;
  logic             valid_q;
  logic             valid_d;
  logic             multi_q;
  logic             multi_d;

  // Synchroniser, previous-sample register, debounce counter and stable
  // vector. fill_q marks when sync2_q and prev_q hold genuine post-reset
  // samples, so the zeros left by reset are never mistaken for a debounced
  // release. armed_q records that a debounced all-released vector has been
  // seen since reset; a key held through reset therefore is not accepted
  // until it has been released and pressed again.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= bus.iKEY;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      fill_q   <= {fill_q[1:0], 1'b1};
      cnt_q    <= cnt_d;
      stable_q <= stableNext;
      armed_q  <= armed_d;
    end
  end

  // Any change of the synchronised keys restarts the count; otherwise count
  // up and park at the terminal value.
  always_comb begin
    cnt_d = '0;
    if (fill_q[2] && (sync2_q == prev_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // The load also requires s2 to still match its previous value, so a change
  // arriving exactly at terminal count cannot slip into the stable vector.
  assign load       = (cnt_q == CNT_MAX) && (sync2_q == prev_q);
  assign stableNext = load ? sync2_q : stable_q;
  assign armed_d    = armed_q | (load && (sync2_q == '0));

  // The FSM judges the vector being loaded this edge, so the accept lands on
  // the same edge as the stable-vector update.
  assign keySingle = (stableNext != '0) && ((stableNext & (stableNext - 10'd1)) == '0);
  assign keyMulti  = (stableNext != '0) && !keySingle;

  // State and registered outputs.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (keyMulti) begin
          state_d = LOCK;
        end else if (keySingle && armed_q) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (stableNext == '0) begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (stableNext == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output updates. Extra or changed keys while HELD leave everything alone.
  always_comb begin
    valid_d  = 1'b0;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    case (state_q)
      IDLE: begin
        if (keyMulti) begin
          multi_d = 1'b1;
        end else if (keySingle && armed_q) begin
          valid_d  = 1'b1;
          onehot_d = stableNext;
        end
      end
      LOCK: begin
        if (stableNext == '0) begin
          multi_d = 1'b0;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.oONEHOT = onehot_q;
  assign bus.oVALID  = valid_q;
  assign bus.oMULTI  = multi_q;

endmodule

// File: doc/key_onehot_scan.md
Name: key_onehot_scan

Overview:
- Front-end stage for the 10-input one-hot encoder.
- Takes 10 raw, asynchronous, active-high key/switch inputs (digits 0-9).
- Synchronises and debounces them, then accepts exactly one key press at a time.
- Presents the accepted key as a held one-hot vector plus a one-cycle valid strobe; the vector feeds the encoder input directly.
- Multi-key presses are rejected and flagged, so the encoder never sees an illegal pattern caused by this block.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive unchanged cycles needed to declare inputs stable (10 ms at 50 MHz). Legal range is 2 to 2^CNT_W-1.
- CNT_W, 20: width of the debounce counter.

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- iRSTn  input  1  synchronous active-low reset.
- iKEY  input  10  raw keys, bit k = digit k, 1 = pressed; asynchronous to iCLK.
- oONEHOT  output  10  last accepted key, one-hot; all zeros = no key accepted since reset.
- oVALID  output  1  one-cycle pulse when a new key is accepted.
- oMULTI  output  1  high while a rejected multi-key press is held.

Behaviour:
- Reset: iRSTn sampled low at a rising edge clears all internal state on that edge.
  - Cleared state: sync flops, previous-sample register, counter, stable vector = 0; FSM = IDLE.
  - Outputs after reset: oONEHOT = 10'b0, oVALID = 0, oMULTI = 0.
  - Reset mid-debounce or mid-press discards all progress. A key still held after reset release must first be seen stable, but is not accepted until it is released and pressed again (FSM starts in IDLE, stable vector starts at 0; see IDLE rule).
- Synchroniser: 2-flop synchroniser per bit, giving s2. A register holds s2 from the previous cycle.
- Debounce counter:
  - Cleared to 0 in any cycle where s2 differs from its previous value.
  - Otherwise increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1, the stable vector is loaded with s2.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the stable vector.
- FSM, evaluated on the stable vector, one state transition per cycle:
  - IDLE: waits for a change of the stable vector away from zero.
    - Exactly one bit set: oONEHOT <= stable vector, oVALID = 1 for one cycle, go to HELD.
    - Two or more bits set: oMULTI <= 1, oONEHOT unchanged, no oVALID, go to LOCK.
    - Stable vector zero: stay in IDLE.
  - HELD: stays while the stable vector is non-zero.
    - Extra keys or a change of key while held are ignored: no oVALID, oONEHOT unchanged, oMULTI stays 0.
    - Stable vector zero: go to IDLE.
  - LOCK: stays while the stable vector is non-zero.
    - Stable vector zero: oMULTI <= 0, go to IDLE.
- Latency:
  - A raw change first present at edge N, held steady, gives oVALID high in the cycle after edge N+DEBOUNCE_CYCLES+2.
  - oONEHOT updates on that same edge.
- Key-identity rules:
  - The same key pressed again after a full release produces a new oVALID.
  - oONEHOT is never multi-hot.
  - oONEHOT holds its value through release and only changes on a new accept.
- Simultaneous events:
  - Keys that become stable in the same cycle count as a multi-press.
  - A second key that arrives within the debounce window of the first restarts the counter. The pair is then judged together as a multi-press.

Test Plan:
- Reset: iRSTn = 0 for 2 cycles with iKEY = 10'h3FF → oONEHOT = 0, oVALID = 0, oMULTI = 0. Release reset with iKEY still 10'h3FF → oMULTI rises after debounce. Release all keys → oMULTI = 0.
- Single press (DEBOUNCE_CYCLES = 4): iKEY = 10'b00_0000_1000 held from edge 10 → exactly one oVALID pulse after edge 16; oONEHOT = 10'b00_0000_1000 (encoder reads 4'b0011). Release → oONEHOT holds, no further pulse.
- Bounce: toggle bit 9 every 2 cycles for 20 cycles, then hold 1 → no oVALID during toggling. One oVALID 6 cycles after toggling ends; oONEHOT = 10'b10_0000_0000.
- Multi-press: iKEY = 10'b00_0000_0011 → oMULTI = 1, no oVALID, oONEHOT keeps its prior value. Release → oMULTI = 0. Then press bit 5 → oVALID with oONEHOT = 10'b00_0010_0000.
- Hold + extra key: hold bit 2 (accepted), then also press bit 7 → no new oVALID, oMULTI = 0, oONEHOT = 10'b00_0000_0100. Release both, press bit 2 again → second oVALID.
- Reset mid-debounce: press bit 0, assert iRSTn = 0 at debounce count 2 → no oVALID. Press held through reset is not accepted until released and re-pressed.
